fetch_cond_sequencer: RTL and testbench
=======================================

# fetch_cond_sequencer

Multi-cycle instruction sequencer around the condition checker. Owns the PC, the instruction register (IR) and the NZCV status register, and fetches instructions over the memory handshake. It presents `IR` and `Flags` to the condition checker and uses the returned pass signal to start or skip execution in the datapath. It updates `Flags` from the ALU for flag-setting data-processing instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MEM_TIMEOUT`, 16, maximum cycles spent in FETCH without `MOC` before faulting (valid range 2..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  32  fetch address, always equal to PC.
- `mem_rd`  out  1  memory read request.
- `mem_rdata`  in  32  instruction word, valid when `MOC`=1.
- `MOC`  in  1  memory operation complete.
- `IR`  out  32  latched instruction, to condition checker and datapath.
- `Flags`  out  4  status register {C,N,V,Z} (bit3=C, bit2=N, bit1=V, bit0=Z).
- `cond_ok`  in  1  condition checker result for current `IR`/`Flags`, combinational.
- `exec_start`  out  1  one-cycle pulse to start datapath execution.
- `exec_done`  in  1  datapath finished; qualifies `alu_flags`, `branch_taken`, `branch_target`.
- `alu_flags`  in  4  {C,N,V,Z} result from ALU.
- `branch_taken`  in  1  instruction redirects PC.
- `branch_target`  in  32  new PC.
- `skip_count`  out  8  instructions skipped by condition, saturates at 255.
- `fault`  out  1  memory timeout fault, sticky until reset.

## Operation
- State machine: FETCH, DECODE, EXECUTE, FAULT. After reset the state is FETCH.
- Reset values: PC=`RESET_PC`, IR=0, Flags=4'b0000, skip_count=0, timer=0, fault=0, exec_start=0. While `reset`=1, `mem_rd` is forced to 0.
- FETCH:
  - `mem_rd`=1, `mem_addr`=PC.
  - On `MOC`=1: IR←`mem_rdata`, PC←PC+4 (modulo 2^32, wraps 32'hFFFF_FFFC→0), timer←0, go to DECODE.
  - Otherwise timer increments. When timer = `MEM_TIMEOUT`−1 and `MOC`=0, go to FAULT.
- DECODE: one cycle; `mem_rd`=0; `cond_ok` is sampled this cycle.
  - Execute when `cond_ok`=1 and IR[31:28]≠4'b1111: go to EXECUTE.
  - Otherwise skip: go to FETCH, and skip_count increments unless already 255. Condition 4'b1111 always skips.
- EXECUTE:
  - `exec_start`=1 in the first EXECUTE cycle only.
  - Remain in EXECUTE until `exec_done`=1. `exec_done` in the first EXECUTE cycle is legal.
  - On `exec_done`:
    - If IR[27:26]=2'b00 and IR[20]=1: Flags←`alu_flags`.
    - If `branch_taken`: PC←{`branch_target`[31:2],2'b00}. This overrides the PC+4 already applied.
    - Go to FETCH.
- FAULT: `mem_rd`=0, `exec_start`=0, `fault`=1. All registers hold; leave only via reset.
- `exec_done`, `branch_taken` and `alu_flags` are ignored outside EXECUTE. `MOC` is ignored outside FETCH.
- Flags change only in EXECUTE on `exec_done`, so `cond_ok` in DECODE always reflects flags from the previous executed instruction.

## Timing
- All state, PC, IR, Flags, skip_count and fault registers update on the rising `clk` edge; `reset` acts immediately, independent of `clk`.
- `mem_rd`, `mem_addr`, `exec_start`, `fault` are decoded from registered state and are glitch-free per cycle.
- Minimum cycles per executed instruction: 3 (FETCH with same-cycle `MOC`, DECODE, EXECUTE with same-cycle `exec_done`).
- Minimum cycles per skipped instruction: 2.
- `IR` is valid from the first DECODE cycle and holds through EXECUTE and the following FETCH until the next `MOC`.
- Timeout: with `MOC` never asserted, FAULT is entered on the clock edge ending FETCH cycle number `MEM_TIMEOUT`; `fault`=1 in the next cycle.
- Reset asserted mid-FETCH or mid-EXECUTE aborts the operation; no Flags or PC update from the aborted instruction.

## Test plan
- Reset, `RESET_PC`=0, memory returns 32'hE0900001 (AL, ADDS) with same-cycle `MOC`, `exec_done` same cycle with `alu_flags`=4'b0001 -> `exec_start` pulses once, Flags=4'b0001, PC=4, 3 cycles total.
- Flags Z=1, fetch 32'h1A000002 (NE branch), checker returns `cond_ok`=0 -> no `exec_start`, skip_count=1, PC=8 after two instructions, FETCH re-entered after 2 cycles.
- EQ branch passes, `exec_done` after 4 cycles with `branch_taken`=1, `branch_target`=32'h0000_0103 -> PC=32'h0000_0100, `mem_addr`=32'h100 in next FETCH, Flags unchanged.
- ADD without S (IR[20]=0) executed with `alu_flags`=4'b1111 -> Flags unchanged.
- `MEM_TIMEOUT`=16, `MOC` held low -> `fault`=1 and `mem_rd`=0 after 16 FETCH cycles, no recovery on later `MOC`; assert `reset` -> PC=`RESET_PC`, `fault`=0.
- 256 consecutive skipped instructions (condition 4'b1111) -> skip_count saturates at 255; `reset` during an EXECUTE wait -> Flags=0, PC=`RESET_PC`, FETCH.

Source files
------------

// File: rtl/fetch_cond_sequencer.sv
// fetch_cond_sequencer: fetch/decode/execute sequencer owning PC, IR, NZCV flags; skips instructions failing cond_ok, faults on fetch timeout
module fetch_cond_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        MOC,
  output logic [31:0] IR,
  output logic [3:0]  Flags,
  input  logic        cond_ok,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic [3:0]  alu_flags,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [7:0]  skip_count,
  output logic        fault
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, FAULT} state_t;
  localparam logic [7:0] TLAST = 8'(MEM_TIMEOUT - 1);
  state_t state;
  logic [31:0] pc;
  logic [7:0] timer;
  assign mem_addr = pc;
  assign mem_rd = state == FETCH && !reset;
  assign fault = state == FAULT;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      IR         <= '0;
      Flags      <= '0;
      skip_count <= '0;
      timer      <= '0;
      exec_start <= 1'b0;
    end else begin
      exec_start <= 1'b0;
      case (state)
        FETCH:
          if (MOC) begin
            IR    <= mem_rdata;
            pc    <= pc + 32'd4;
            timer <= '0;
            state <= DECODE;
          end else if (timer == TLAST) begin
            state <= FAULT;
          end else begin
            timer <= timer + 8'd1;
          end
        DECODE:
          if (cond_ok && IR[31:28] != 4'hF) begin
            state      <= EXECUTE;
            exec_start <= 1'b1;
          end else begin
            state      <= FETCH;
            skip_count <= skip_count == 8'hFF ? skip_count : skip_count + 8'd1;
          end
        EXECUTE:
          if (exec_done) begin
            if (IR[27:26] == 2'b00 && IR[20]) Flags <= alu_flags;
            if (branch_taken) pc <= {branch_target[31:2], 2'b00};
            state <= FETCH;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fetch_cond_sequencer.sv
// tb_fetch_cond_sequencer: directed vectors with a queue scoreboard checked by an event-driven monitor
module tb_fetch_cond_sequencer;
  logic clk = 0, reset;
  logic [31:0] mem_addr, mem_rdata, IR, branch_target;
  logic mem_rd, MOC, cond_ok, exec_start, exec_done, branch_taken, fault;
  logic [3:0] Flags, alu_flags;
  logic [7:0] skip_count;
  fetch_cond_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .MOC(MOC), .IR(IR), .Flags(Flags), .cond_ok(cond_ok), .exec_start(exec_start),
    .exec_done(exec_done), .alu_flags(alu_flags), .branch_taken(branch_taken),
    .branch_target(branch_target), .skip_count(skip_count), .fault(fault)
  );
  always #5 clk = ~clk;
  typedef enum int {K_FETCH, K_EXEC, K_FAULT} kind_t;
  typedef struct {
    kind_t k;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [3:0] flags;
    logic [7:0] skip;
    int cyc;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  logic [31:0] last_addr = 0;
  logic prev_rd = 0, prev_fault = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask
  task automatic push(input kind_t k, input logic [31:0] a, input logic [31:0] ir, input logic [3:0] f,
                      input logic [7:0] s, input int c);
    exp_t e;
    e.k = k; e.addr = a; e.ir = ir; e.flags = f; e.skip = s; e.cyc = c;
    q.push_back(e);
    if (k == K_FETCH) last_addr = a;
  endtask
  always @(negedge clk) begin
    exp_t e;
    kind_t k;
    if ((mem_rd && !prev_rd) || exec_start || (fault && !prev_fault)) begin
      k = exec_start ? K_EXEC : (fault && !prev_fault) ? K_FAULT : K_FETCH;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event actual=%0d required=none cyc=%0d", k, cyc);
      end else begin
        e = q.pop_front();
        chk("kind", 32'(k), 32'(e.k));
        chk("cycle", 32'(cyc), 32'(e.cyc));
        chk("mem_addr", mem_addr, e.addr);
        if (e.k == K_FETCH) begin
          chk("flags", 32'(Flags), 32'(e.flags));
          chk("skip_count", 32'(skip_count), 32'(e.skip));
          chk("fault_low", 32'(fault), 32'd0);
        end else if (e.k == K_EXEC) begin
          chk("ir", IR, e.ir);
        end else begin
          chk("fault_mem_rd", 32'(mem_rd), 32'd0);
        end
      end
    end
    prev_rd <= mem_rd;
    prev_fault <= fault;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] word, input int md, input logic cok, input logic ex, input int dd,
                     input logic [3:0] af, input logic bt, input logic [31:0] tgt,
                     input logic [31:0] ea, input logic [3:0] ef, input logic [7:0] es);
    int c0;
    c0 = cyc;
    if (ex) push(K_EXEC, last_addr + 32'd4, word, 4'h0, 8'h0, c0 + md + 2);
    push(K_FETCH, ea, 32'h0, ef, es, c0 + md + 2 + (ex ? dd + 1 : 0));
    repeat (md) step();
    MOC = 1; mem_rdata = word;
    step();
    MOC = 0; mem_rdata = 32'hDEAD_BEEF; cond_ok = cok;
    step();
    cond_ok = 0;
    if (ex) begin
      alu_flags = 4'hF; branch_taken = 1;
      repeat (dd) step();
      exec_done = 1; alu_flags = af; branch_taken = bt; branch_target = tgt;
      step();
      exec_done = 0; branch_taken = 0; alu_flags = 4'h0;
    end
  endtask
  initial begin
    int c0;
    reset = 1; MOC = 0; mem_rdata = 0; cond_ok = 0; exec_done = 0;
    alu_flags = 0; branch_taken = 0; branch_target = 0;
    repeat (2) step();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_flags", 32'(Flags), 32'd0);
    chk("rst_exec_start", 32'(exec_start), 32'd0);
    push(K_FETCH, 32'h0, 32'h0, 4'h0, 8'h0, cyc);
    reset = 0;
    run(32'hE090_0001, 0, 1, 1, 0, 4'b0001, 0, 32'h0,         32'h0000_0004, 4'b0001, 8'd0);
    run(32'h1A00_0002, 0, 0, 0, 0, 4'b0000, 0, 32'h0,         32'h0000_0008, 4'b0001, 8'd1);
    run(32'h0A00_0010, 1, 1, 1, 3, 4'b1111, 1, 32'h0000_0103, 32'h0000_0100, 4'b0001, 8'd1);
    run(32'hE080_0001, 0, 1, 1, 0, 4'b1111, 0, 32'h0,         32'h0000_0104, 4'b0001, 8'd1);
    run(32'hE090_0001, 2, 1, 1, 1, 4'b1010, 0, 32'h0,         32'h0000_0108, 4'b1010, 8'd1);
    run(32'hE590_0000, 0, 1, 1, 0, 4'b1111, 0, 32'h0,         32'h0000_010C, 4'b1010, 8'd1);
    run(32'hEA00_0000, 0, 1, 1, 0, 4'b0000, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 4'b1010, 8'd1);
    run(32'hF000_0000, 0, 1, 0, 0, 4'b0000, 0, 32'h0,         32'h0000_0000, 4'b1010, 8'd2);
    run(32'hF000_0000, 0, 1, 0, 0, 4'b0000, 0, 32'h0,         32'h0000_0004, 4'b1010, 8'd3);
    push(K_FAULT, 32'h4, 32'h0, 4'h0, 8'h0, cyc + 16);
    repeat (20) step();
    chk("fault_set", 32'(fault), 32'd1);
    MOC = 1; mem_rdata = 32'hE090_0001;
    repeat (3) step();
    MOC = 0;
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_no_fetch", 32'(mem_rd), 32'd0);
    #2 reset = 1;
    #1;
    chk("rst2_mem_addr", mem_addr, 32'h0);
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_skip", 32'(skip_count), 32'd0);
    chk("rst2_flags", 32'(Flags), 32'd0);
    step();
    push(K_FETCH, 32'h0, 32'h0, 4'h0, 8'h0, cyc);
    reset = 0;
    for (int n = 1; n <= 256; n++)
      run(32'hF000_0000, 0, 1, 0, 0, 4'h0, 0, 32'h0, 32'(n * 4), 4'h0, n > 255 ? 8'd255 : 8'(n));
    run(32'hE090_0001, 0, 1, 1, 0, 4'b0110, 0, 32'h0, 32'h0000_0404, 4'b0110, 8'd255);
    c0 = cyc;
    push(K_EXEC, 32'h0000_0408, 32'hE090_0001, 4'h0, 8'h0, c0 + 2);
    MOC = 1; mem_rdata = 32'hE090_0001;
    step();
    MOC = 0; cond_ok = 1;
    step();
    cond_ok = 0; alu_flags = 4'hF; branch_taken = 1; branch_target = 32'h500;
    repeat (2) step();
    #2 reset = 1;
    #1;
    chk("rst3_flags", 32'(Flags), 32'd0);
    chk("rst3_mem_addr", mem_addr, 32'h0);
    chk("rst3_ir", IR, 32'h0);
    chk("rst3_exec_start", 32'(exec_start), 32'd0);
    branch_taken = 0; alu_flags = 0;
    step();
    push(K_FETCH, 32'h0, 32'h0, 4'h0, 8'h0, cyc);
    reset = 0;
    run(32'hE090_0001, 0, 1, 1, 0, 4'b0001, 0, 32'h0, 32'h0000_0004, 4'b0001, 8'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0 pending events", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
